stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Stopwatch controller sequencing a 6-digit BCD time chain (MM:SS.cc, 00:00.00-59:59.99).
//  Decodes start/stop, lap and clear pulses into a run/pause/lap FSM, divides clk to a 100 Hz tick,
//  and advances the cascaded BCD digits with synchronous enables (no rippled clocks).
//  Sits between the button debouncers and the 7-segment display multiplexer.
// PARAMETERS
//  TICK_DIV  500000  clk cycles per centisecond tick (50 MHz / 100 Hz); must be >= 2
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  reset           in   1   asynchronous, active-low; 0 forces reset state immediately
//  btn_start_stop  in   1   1-cycle pulse, synchronised/debounced upstream
//  btn_lap         in   1   1-cycle pulse
//  btn_clear       in   1   1-cycle pulse
//  disp            out  24  {m1,m0,s1,s0,c1,c0}, 4-bit BCD each, c0 at [3:0]
//  running         out  1   1 in RUN or LAP
//  lap_active      out  1   1 in LAP (display frozen)
//  tick            out  1   1-cycle centisecond strobe (counting states only)
//  wrap            out  1   1-cycle pulse when count rolls 59:59.99 -> 00:00.00
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, prescaler=0, all digits=0, lap latch=0; disp=0, running=0,
//   lap_active=0, tick=0, wrap=0. All outputs registered.
//  FSM states IDLE, RUN, PAUSE, LAP. Simultaneous pulses: clear > start_stop > lap; lower ignored.
//   IDLE : start_stop -> RUN; lap, clear ignored (count already 0).
//   RUN  : start_stop -> PAUSE; lap -> LAP (latch live count into lap latch same edge); clear ignored.
//   LAP  : lap -> RUN (display live again); start_stop -> PAUSE (display live); clear ignored.
//   PAUSE: start_stop -> RUN; clear -> IDLE (digits, prescaler zeroed on that edge); lap ignored.
//  State change visible the cycle after the pulse edge.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP; held (not cleared) in PAUSE so phase resumes;
//   zeroed in IDLE. tick=1 for the cycle prescaler==TICK_DIV-1 in RUN/LAP; prescaler wraps to 0.
//   First tick after IDLE->RUN: TICK_DIV cycles after state becomes RUN.
//  Digit chain advances on the edge ending a tick cycle (new value visible the cycle after tick):
//   c0 0-9, c1 0-9, s0 0-9, s1 0-5, m0 0-9, m1 0-5. Digit carries when all lower digits are at max.
//   At 59:59.99 + tick -> 00:00.00, wrap=1 for that one cycle (aligned with new zero value), keeps running.
//  disp = lap latch when in LAP, otherwise live digits. Digits never hold non-BCD values.
//  Pulse arriving in same cycle as tick: tick's increment still applies (increment, then state change).
//   E.g. start_stop with tick in RUN: count advances, state -> PAUSE.
//  Reset mid-count: immediate return to reset values; no tick/wrap emitted.
// TESTING (run with TICK_DIV=4)
//  1 reset low 3 cycles, release -> disp=0, running=0, no tick for 20 idle cycles.
//  2 start_stop; 40 cycles -> running=1, 10 ticks, disp=0x000010 (00:00.10), tick period 4.
//  3 preload/run to 59:59.99 (0x595999), next tick -> disp=0x000000, wrap=1 one cycle, running=1.
//  4 RUN at 00:00.05, lap -> lap_active=1, disp stays 0x000005 while live advances 8 ticks;
//    lap again -> disp=0x000013.
//  5 RUN, start_stop 2 cycles after a tick -> PAUSE, disp frozen; start_stop again -> next tick
//    2 cycles later (phase kept); then stop, clear -> IDLE, disp=0; clear in RUN has no effect.
//  6 start_stop+clear same cycle in PAUSE -> IDLE (clear wins); reset low mid-RUN -> all outputs 0 at once.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap stopwatch FSM driving a 6-digit BCD MM:SS.cc chain from a 100 Hz prescaler
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   btn_start_stop 1-cycle pulse: IDLE/PAUSE -> RUN, RUN/LAP -> PAUSE
//   btn_lap        1-cycle pulse: RUN <-> LAP
//   btn_clear      1-cycle pulse: PAUSE -> IDLE with count zeroed
//   disp           {m1,m0,s1,s0,c1,c0} BCD, lap latch while in LAP
//   running        1 in RUN or LAP
//   lap_active     1 in LAP
//   tick           centisecond strobe, high in the cycle the count advances
//   wrap           high for one cycle together with the 00:00.00 after 59:59.99
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        tick,
  output logic        wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  // per-digit maximum, m1..c0, same packing as disp
  localparam logic [23:0] DMAX = 24'h595999;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
  state_t r_state, w_nxt;
  logic [PW-1:0] r_presc, w_presc;
  logic [23:0] r_dig, w_dig, r_latch, w_latch, r_disp;
  logic r_running, r_lap, r_tick, r_wrap;
  logic w_ss, w_lap, w_clr, w_cnt, w_tick, w_carry, w_nxt_cnt;
  // clear outranks start_stop, which outranks lap
  assign w_clr  = btn_clear;
  assign w_ss   = btn_start_stop & ~btn_clear;
  assign w_lap  = btn_lap & ~btn_start_stop & ~btn_clear;
  assign w_cnt  = r_state == S_RUN || r_state == S_LAP;
  assign w_tick = w_cnt && r_presc == PMAX;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = w_ss ? S_RUN : S_IDLE;
      S_RUN:   w_nxt = w_ss ? S_PAUSE : w_lap ? S_LAP : S_RUN;
      S_LAP:   w_nxt = w_ss ? S_PAUSE : w_lap ? S_RUN : S_LAP;
      default: w_nxt = w_clr ? S_IDLE : w_ss ? S_RUN : S_PAUSE;
    endcase
  end
  assign w_nxt_cnt = w_nxt == S_RUN || w_nxt == S_LAP;
  // prescaler keeps its phase across PAUSE so resuming does not shorten/lengthen a centisecond
  assign w_presc = w_nxt == S_IDLE ? '0 : !w_cnt ? r_presc : r_presc == PMAX ? '0 : r_presc + 1'b1;
  // cascaded synchronous increment: a digit steps only when every lower digit is at its maximum
  always_comb begin
    w_dig   = r_dig;
    w_carry = w_tick;
    for (int i = 0; i < 6; i++) begin
      if (w_carry) begin
        w_dig[4*i+:4] = r_dig[4*i+:4] == DMAX[4*i+:4] ? 4'd0 : r_dig[4*i+:4] + 4'd1;
        w_carry       = r_dig[4*i+:4] == DMAX[4*i+:4];
      end
    end
    if (r_state == S_PAUSE && w_clr)
      w_dig = '0;
  end
  // latch takes the post-increment count when lap coincides with a tick
  assign w_latch = (r_state == S_RUN && w_lap) ? w_dig : r_latch;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_dig     <= '0;
      r_latch   <= '0;
      r_disp    <= '0;
      r_running <= 1'b0;
      r_lap     <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_presc   <= w_presc;
      r_dig     <= w_dig;
      r_latch   <= w_latch;
      r_disp    <= w_nxt == S_LAP ? w_latch : w_dig;
      r_running <= w_nxt_cnt;
      r_lap     <= w_nxt == S_LAP;
      r_tick    <= w_nxt_cnt && w_presc == PMAX;
      r_wrap    <= w_carry;
    end
  end
  assign disp       = r_disp;
  assign running    = r_running;
  assign lap_active = r_lap;
  assign tick       = r_tick;
  assign wrap       = r_wrap;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with TICK_DIV=4
module tb_stopwatch_ctrl;
  logic clk = 1'b0, reset = 1'b0, ss = 1'b0, lp = 1'b0, cl = 1'b0;
  logic [23:0] disp;
  logic running, lap_active, tick, wrap;
  int total = 0, bad = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .btn_start_stop(ss), .btn_lap(lp), .btn_clear(cl),
    .disp(disp), .running(running), .lap_active(lap_active), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; ss = 1'b0; lp = 1'b0; cl = 1'b0;
    cyc(3);
    reset = 1'b1;
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    ss = s; lp = l; cl = c;
    @(negedge clk);
    ss = 1'b0; lp = 1'b0; cl = 1'b0;
  endtask

  task automatic test_reset;
    int n = 0, nz = 0;
    reset = 1'b0;
    cyc(3);
    total++;
    if ({disp, running, lap_active, tick, wrap} !== 28'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {disp, running, lap_active, tick, wrap});
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tick) n++;
      if (disp !== 24'h0 || running !== 1'b0) nz++;
      cyc(1);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL idle_ticks: got %0d want 0", n); end
    total++;
    if (nz !== 0) begin bad++; $display("FAIL idle_outputs: got %0d nonzero cycles want 0", nz); end
  endtask

  task automatic test_count;
    int n = 0, last = -1, perr = 0;
    do_reset;
    press(1, 0, 0);
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL run_running: got %b want 1", running); end
    for (int i = 0; i < 40; i++) begin
      if (tick) begin
        if (i - last != 4) perr++;
        last = i;
        n++;
      end
      cyc(1);
    end
    total++;
    if (n !== 10) begin bad++; $display("FAIL run_ticks: got %0d want 10", n); end
    total++;
    if (perr !== 0) begin bad++; $display("FAIL tick_period: got %0d bad gaps want 0", perr); end
    total++;
    if (disp !== 24'h000010) begin bad++; $display("FAIL run_disp: got %h want 000010", disp); end
  endtask

  task automatic test_wrap;
    do_reset;
    @(negedge clk);
    force dut.r_dig = 24'h595999;
    @(negedge clk);
    release dut.r_dig;
    total++;
    if (disp !== 24'h595999) begin bad++; $display("FAIL preload_disp: got %h want 595999", disp); end
    press(1, 0, 0);
    cyc(3);
    total++;
    if (tick !== 1'b1 || disp !== 24'h595999 || wrap !== 1'b0) begin
      bad++; $display("FAIL pre_wrap: got tick=%b disp=%h wrap=%b want 1 595999 0", tick, disp, wrap);
    end
    cyc(1);
    total++;
    if (disp !== 24'h0 || wrap !== 1'b1 || running !== 1'b1) begin
      bad++; $display("FAIL wrap: got disp=%h wrap=%b running=%b want 000000 1 1", disp, wrap, running);
    end
    cyc(1);
    total++;
    if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_width: got %b want 0", wrap); end
  endtask

  task automatic test_lap;
    int n = 0, moved = 0;
    do_reset;
    press(1, 0, 0);
    cyc(20);
    total++;
    if (disp !== 24'h000005) begin bad++; $display("FAIL lap_pre: got %h want 000005", disp); end
    press(0, 1, 0);
    total++;
    if (lap_active !== 1'b1 || running !== 1'b1) begin
      bad++; $display("FAIL lap_enter: got lap=%b run=%b want 1 1", lap_active, running);
    end
    for (int i = 0; i < 31; i++) begin
      if (tick) n++;
      if (disp !== 24'h000005) moved++;
      cyc(1);
    end
    total++;
    if (n !== 8) begin bad++; $display("FAIL lap_ticks: got %0d want 8", n); end
    total++;
    if (moved !== 0) begin bad++; $display("FAIL lap_frozen: got %0d changed cycles want 0", moved); end
    press(0, 1, 0);
    total++;
    if (disp !== 24'h000013 || lap_active !== 1'b0 || running !== 1'b1) begin
      bad++; $display("FAIL lap_exit: got disp=%h lap=%b run=%b want 000013 0 1", disp, lap_active, running);
    end
  endtask

  task automatic test_pause;
    int n = 0, moved = 0;
    logic [3:0] tv;
    do_reset;
    press(1, 0, 0);
    cyc(5);
    press(1, 0, 0);
    total++;
    if (running !== 1'b0 || disp !== 24'h000001) begin
      bad++; $display("FAIL pause_enter: got run=%b disp=%h want 0 000001", running, disp);
    end
    for (int i = 0; i < 10; i++) begin
      if (tick) n++;
      if (disp !== 24'h000001) moved++;
      cyc(1);
    end
    total++;
    if (n !== 0 || moved !== 0) begin
      bad++; $display("FAIL pause_hold: got ticks=%0d changes=%0d want 0 0", n, moved);
    end
    press(1, 0, 0);
    tv[0] = tick;
    cyc(1);
    tv[1] = tick;
    total++;
    if (tv[1:0] !== 2'b10 || running !== 1'b1) begin
      bad++; $display("FAIL resume_phase: got ticks=%b run=%b want 10 1", tv[1:0], running);
    end
    cyc(1);
    total++;
    if (disp !== 24'h000002) begin bad++; $display("FAIL resume_count: got %h want 000002", disp); end
    press(1, 0, 0);
    press(0, 0, 1);
    total++;
    if (running !== 1'b0 || disp !== 24'h0 || lap_active !== 1'b0) begin
      bad++; $display("FAIL clear: got run=%b disp=%h want 0 000000", running, disp);
    end
    press(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tv[i] = tick;
      if (i < 3) cyc(1);
    end
    total++;
    if (tv !== 4'b1000) begin bad++; $display("FAIL clear_presc: got %b want 1000", tv); end
    cyc(1);
    press(0, 0, 1);
    total++;
    if (running !== 1'b1 || disp !== 24'h000001) begin
      bad++; $display("FAIL clear_in_run: got run=%b disp=%h want 1 000001", running, disp);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    press(1, 0, 0);
    cyc(8);
    press(1, 0, 0);
    total++;
    if (disp !== 24'h000002 || running !== 1'b0) begin
      bad++; $display("FAIL b2b_pause: got disp=%h run=%b want 000002 0", disp, running);
    end
    press(1, 0, 1);
    cyc(5);
    total++;
    if (running !== 1'b0 || disp !== 24'h0 || tick !== 1'b0) begin
      bad++; $display("FAIL clear_wins: got run=%b disp=%h tick=%b want 0 000000 0", running, disp, tick);
    end
    press(1, 0, 0);
    cyc(11);
    total++;
    if (tick !== 1'b1 || disp !== 24'h000002) begin
      bad++; $display("FAIL pre_async: got tick=%b disp=%h want 1 000002", tick, disp);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({disp, running, lap_active, tick, wrap} !== 28'h0) begin
      bad++; $display("FAIL async_reset: got %h want 0", {disp, running, lap_active, tick, wrap});
    end
    cyc(2);
    reset = 1'b1;
    cyc(1);
    total++;
    if (disp !== 24'h0 || running !== 1'b0) begin
      bad++; $display("FAIL post_reset: got disp=%h run=%b want 000000 0", disp, running);
    end
  endtask

  initial begin
    test_reset;
    test_count;
    test_wrap;
    test_lap;
    test_pause;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
